aline_receive_fsm: RTL

Receive-side counterpart to the A-line pulse transmit path. After a pulse is fired and the AFE is switched to receive, it waits a programmable start delay, then captures a programmed number of ADC samples into an internal buffer. It then serialises them byte-by-byte to the UART transmitter under a valid/ready handshake. It sits between the ADC front end and the UART TX, driven by the image-level transmit sequencer, which issues one `start_receive` per A-line.

---
 rtl/aline_receive_fsm_pkg.sv | 22 ++
 rtl/aline_receive_fsm_sample_buffer.sv | 24 ++
 rtl/aline_receive_fsm.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aline_receive_fsm_pkg.sv
// Shared definitions for the A-line receive path: FSM state encoding and the
// header nibble that tags every A-line on the UART stream.
package aline_receive_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DELAY    = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_PREFETCH = 3'd3,
    ST_HEADER   = 3'd4,
    ST_SEND_HI  = 3'd5,
    ST_SEND_LO  = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  function automatic logic [7:0] header_byte(input logic [3:0] idx);
    return {HDR_NIBBLE, idx};
  endfunction

endpackage

// File: rtl/aline_receive_fsm_sample_buffer.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module sample_buffer #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/aline_receive_fsm.sv
// A-line receive sequencer: start delay, ADC capture into a local buffer, then
// byte-serial readout (header, then hi/lo byte per sample) to the UART TX.
module aline_receive_fsm
  import aline_receive_fsm_pkg::*;
#(
  parameter int ADC_WIDTH  = 10,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_receive,
  input  logic [15:0]          start_delay,
  input  logic [15:0]          num_samples,
  input  logic [3:0]           aline_index,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 capture_in_progress,
  output logic                 receive_complete
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, next_state;

  logic [15:0]          delay_cnt;
  logic [CNT_W-1:0]     n_eff;
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     rd_cnt;
  logic [CNT_W-1:0]     rd_cnt_inc;
  logic [3:0]           aline_idx;
  logic [ADC_WIDTH-1:0] rd_data;

  logic                  buf_we;
  logic                  buf_re;
  logic [ADDR_WIDTH-1:0] buf_raddr;

  logic       hs;
  logic       more;
  logic [7:0] tx_data_d;
  logic       tx_valid_d;
  logic       busy_d;
  logic       cap_d;
  logic       done_d;

  // Requests beyond the buffer size saturate at DEPTH samples.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [15:0] n);
    if (n > 16'(DEPTH)) return CNT_W'(DEPTH);
    return n[CNT_W-1:0];
  endfunction

  function automatic logic [7:0] hi_byte(input logic [ADC_WIDTH-1:0] s);
    return 8'(16'(s) >> 8);
  endfunction

  function automatic logic [7:0] lo_byte(input logic [ADC_WIDTH-1:0] s);
    return s[7:0];
  endfunction

  assign hs         = tx_valid & tx_ready;
  assign rd_cnt_inc = rd_cnt + CNT_ONE;
  assign more       = rd_cnt_inc < n_eff;

  // The low byte is latched from rd_data as SEND_LO is entered, so the next
  // sample's read is launched on that same edge and is ready before SEND_HI.
  assign buf_we    = (state == ST_CAPTURE) && adc_valid && (wr_cnt != n_eff);
  assign buf_re    = (state == ST_PREFETCH) || ((state == ST_SEND_HI) && hs);
  assign buf_raddr = (state == ST_SEND_HI) ? rd_cnt_inc[ADDR_WIDTH-1:0] : '0;

  sample_buffer #(
    .DATA_W (ADC_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_WIDTH)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (wr_cnt[ADDR_WIDTH-1:0]),
    .wr_data (adc_data),
    .re      (buf_re),
    .rd_addr (buf_raddr),
    .rd_data (rd_data)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:     if (start_receive) next_state = (start_delay != 16'd0) ? ST_DELAY : ST_CAPTURE;
      ST_DELAY:    if (delay_cnt == 16'd1) next_state = ST_CAPTURE;
      ST_CAPTURE:  if (wr_cnt == n_eff) next_state = ST_PREFETCH;
      ST_PREFETCH: next_state = ST_HEADER;
      ST_HEADER:   if (hs) next_state = (n_eff == '0) ? ST_DONE : ST_SEND_HI;
      ST_SEND_HI:  if (hs) next_state = ST_SEND_LO;
      ST_SEND_LO:  if (hs) next_state = more ? ST_SEND_HI : ST_DONE;
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered copies line up
  // exactly with the state they describe.
  always_comb begin
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;
    busy_d     = (next_state != ST_IDLE);
    cap_d      = (next_state == ST_DELAY) || (next_state == ST_CAPTURE);
    done_d     = (next_state == ST_DONE);
    unique case (next_state)
      ST_HEADER: begin
        tx_data_d  = header_byte(aline_idx);
        tx_valid_d = 1'b1;
      end
      ST_SEND_HI: begin
        tx_data_d  = hi_byte(rd_data);
        tx_valid_d = 1'b1;
      end
      ST_SEND_LO: begin
        tx_data_d  = lo_byte(rd_data);
        tx_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= ST_IDLE;
      tx_data             <= 8'h00;
      tx_valid            <= 1'b0;
      busy                <= 1'b0;
      capture_in_progress <= 1'b0;
      receive_complete    <= 1'b0;
    end else begin
      state               <= next_state;
      tx_valid            <= tx_valid_d;
      busy                <= busy_d;
      capture_in_progress <= cap_d;
      receive_complete    <= done_d;
      // Byte is only reloaded on a state change, holding it across backpressure.
      if (next_state != state) tx_data <= tx_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_cnt <= 16'd0;
      n_eff     <= '0;
      aline_idx <= 4'h0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      if (state == ST_IDLE && start_receive) begin
        delay_cnt <= start_delay;
        n_eff     <= clamp_count(num_samples);
        aline_idx <= aline_index;
        wr_cnt    <= '0;
      end else if (state == ST_DELAY) begin
        delay_cnt <= delay_cnt - 16'd1;
      end
      if (buf_we) wr_cnt <= wr_cnt + CNT_ONE;
      if (state == ST_PREFETCH) rd_cnt <= '0;
      else if (state == ST_SEND_LO && hs) rd_cnt <= rd_cnt_inc;
    end
  end

endmodule
